spi_reg_bridge: RTL
===================

Name: spi_reg_bridge

Overview:
Parametrised SPI-slave-to-register bridge for TinyQV peripheral test harnesses. Replaces the fixed 6-bit/32-bit SPI register block with configurable address and data widths, per-frame 8/16/32-bit transactions, and read-wait handshaking on data_ready. An optional burst mode auto-increments the address. It sits between the harness pins and the peripheral-under-test register bus.

Parameters:
ADDR_W, 6, register address width in bits (1..8)
DATA_W, 32, register data width in bits (8, 16 or 32)
SYNC_STAGES, 2, flops in the internal synchroniser on spi_cs_n/spi_clk/spi_mosi (>=2)
DUMMY_BITS, 8, SPI clocks between the read header and the first read data bit (>=2)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-high reset
ena  in  1  bridge enable; low forces IDLE and ignores SPI
spi_cs_n  in  1  chip select, active low, asynchronous to clk
spi_clk  in  1  SPI clock, mode 0, asynchronous to clk
spi_mosi  in  1  SPI data in, MSB first
spi_miso  out  1  SPI data out, MSB first
reg_addr  out  ADDR_W  register address, held stable from header completion until frame end
reg_wdata  out  DATA_W  write data, LSB-aligned, unused upper bits zero
data_write_n  out  2  write strobe: txn width for one clk, else 2'b11
data_read_n  out  2  read strobe: txn width for one clk, else 2'b11
reg_rdata  in  DATA_W  read data from peripheral
data_ready  in  1  read data valid; may coincide with the read strobe cycle
rd_late  out  1  one-clk pulse when a read data phase starts before data_ready was seen

Behaviour:
- Reset: all outputs low except data_write_n=data_read_n=2'b11; state IDLE; synchroniser flops cleared to idle values (cs_n=1, clk=0).
- Inputs pass through SYNC_STAGES flops; SPI rising/falling edges detected from the synchronised clock against its previous value. MOSI is sampled on the rising edge; MISO updates on the falling edge.
- Frame format: header = rw (1=write), txn[1:0], addr[ADDR_W-1:0]; then data of width W = 8<<txn bits.
- txn=11 is treated as 32 bits.
- txn wider than DATA_W is clamped to DATA_W, and that clamped value is what appears on the strobes.
- States:
  - IDLE -> HDR on cs_n falling.
  - HDR: counts 3+ADDR_W rising edges. Write -> WDATA. Read -> issue data_read_n=txn on the clk after the last header bit, then RDUMMY.
  - WDATA: shifts W bits. On the clk after the last bit: reg_wdata valid and data_write_n=txn for exactly one cycle, then DONE.
  - RDUMMY: counts DUMMY_BITS rising edges. Captures reg_rdata (masked to W bits) on the first cycle data_ready=1 after the strobe. On the falling edge ending the last dummy bit, loads the shift register with the captured data, or zeros plus an rd_late pulse if not yet captured, then RDATA.
  - RDATA: drives W bits MSB first (bit W-1 first), then DONE.
  - DONE: ignores spi_clk until cs_n rises.
- cs_n rising in any state: return to IDLE next clk.
  - Partial writes are discarded; no strobe is issued.
  - A pending read capture is cancelled; a late data_ready is ignored.
  - spi_miso returns to 0.
- ena low: state forced to IDLE, strobes 11. A frame already in progress is dropped.
- spi_miso is 0 outside RDATA, except the last dummy bit, which drives 1 if read data was captured (ready flag).
- A strobe is at most one clk wide; write and read strobes never assert together.
- Synchronous rst mid-frame: behaves exactly as power-on reset; any strobe in that cycle is suppressed.

Optional Feature:
SPI_REG_BRIDGE_BURST_EN.
- Defined: DONE is replaced by continuation while cs_n stays low.
  - reg_addr += (W/8), wrapping modulo 2^ADDR_W.
  - Write: re-enter WDATA and issue one strobe per W bits.
  - Read: the next data_read_n is issued on the clk after the last data bit, then RDUMMY/RDATA repeat.
  - A burst aborted by cs_n mid-word follows the abort rules above.
- Undefined: single transaction per frame; extra clocks are ignored in DONE.

Test Plan:
- Write: cs low, header 1,10,addr 6'h05, data 32'hDEADBEEF -> one-cycle data_write_n=2'b10, reg_addr=5, reg_wdata=DEADBEEF; no read strobe.
- 8-bit read: header 0,00,addr 6'h3F, data_ready asserted 3 clk after strobe with reg_rdata=32'h12345678 -> data_read_n=00 for 1 clk; ready flag=1 on last dummy bit; MISO shifts 8'h78; rd_late=0.
- Late read: data_ready held low through dummy phase -> rd_late pulse, MISO all zeros for 16 bits, and a later data_ready is ignored.
- Abort: write header, then cs_n rises after 12 data bits -> no data_write_n strobe; the next full frame works normally.
- Reset/enable: assert rst mid-WDATA, then ena low for a complete frame -> outputs at reset values, no strobes; after ena high a frame succeeds.
- Burst (BURST_EN): 16-bit write at addr 6'h3E, 3 words 0x1111/0x2222/0x3333 -> strobes at addr 3E, 00, 02 (wrap) with matching data; undefined macro -> single strobe only.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns framed header/data transfers into register-bus strobes.
// Optional burst continuation (auto-incrementing address) is enabled by `define SPI_REG_BRIDGE_BURST_EN.
module spi_reg_bridge #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DUMMY_BITS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic [1:0]        data_write_n,
  output logic [1:0]        data_read_n,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              data_ready,
  output logic              rd_late
);

  localparam int         HDR_BITS = 3 + ADDR_W;
  localparam int         CNT_MAX  = (DUMMY_BITS > 32) ? DUMMY_BITS : 32;
  localparam int         CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [1:0] TXN_MAX  = (DATA_W == 8) ? 2'd0 : (DATA_W == 16) ? 2'd1 : 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_WDATA, S_RDUMMY, S_RDATA, S_DONE} state_e;

  function automatic logic [1:0] clamp_txn(input logic [1:0] raw);
    logic [1:0] t;
    t = (raw == 2'b11) ? 2'b10 : raw;
    return (t > TXN_MAX) ? TXN_MAX : t;
  endfunction

  function automatic logic [DATA_W-1:0] width_mask(input logic [1:0] txn);
    logic [DATA_W-1:0] m;
    m = '1;
    return m >> (DATA_W - (8 << txn));
  endfunction

  function automatic logic [CNT_W-1:0] word_last(input logic [1:0] txn);
    return CNT_W'((8 << txn) - 1);
  endfunction

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic cs_prev_q, sclk_prev_q;
  logic cs_s, sclk_s, mosi_s, sclk_rise, sclk_fall;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HDR_BITS-2:0] hdr_q, hdr_d;
  logic [HDR_BITS-1:0] hdr_next;
  logic [1:0]        txn_q, txn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] shift_q, shift_d, wdata_q, wdata_d, rcap_q, rcap_d, mask_cur;
  logic [1:0]        wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic              wait_q, wait_d, ready_q, ready_d, miso_q, miso_d, late_q, late_d;
`ifdef SPI_REG_BRIDGE_BURST_EN
  logic              inc_q, inc_d;
`endif

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign hdr_next  = {hdr_q, mosi_s};
  assign mask_cur  = width_mask(txn_q);

  always_comb begin
    // NOTE: every _d takes its held value first, so no branch can leave a latch behind.
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    txn_d   = txn_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    wdata_d = wdata_q;
    rcap_d  = rcap_q;
    wait_d  = wait_q;
    ready_d = ready_q;
    miso_d  = miso_q;
    wr_n_d  = 2'b11;
    rd_n_d  = 2'b11;
    late_d  = 1'b0;
`ifdef SPI_REG_BRIDGE_BURST_EN
    inc_d = 1'b0;
    if (inc_q) addr_d = addr_q + ADDR_W'(32'd1 << txn_q);
`endif

    if (wait_q && data_ready) begin
      rcap_d  = reg_rdata & mask_cur;
      ready_d = 1'b1;
      wait_d  = 1'b0;
    end

    if (!ena || (cs_s && state_q != S_IDLE)) begin
      state_d = S_IDLE;
      wait_d  = 1'b0;
      ready_d = 1'b0;
      miso_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d  = '0;
          miso_d = 1'b0;
          if (!cs_s && cs_prev_q) state_d = S_HDR;
        end
        S_HDR: if (sclk_rise) begin
          hdr_d = hdr_next[HDR_BITS-2:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(HDR_BITS - 1)) begin
            cnt_d  = '0;
            txn_d  = clamp_txn(hdr_next[ADDR_W+1:ADDR_W]);
            addr_d = hdr_next[ADDR_W-1:0];
            if (hdr_next[HDR_BITS-1]) begin
              state_d = S_WDATA;
            end else begin
              rd_n_d  = clamp_txn(hdr_next[ADDR_W+1:ADDR_W]);
              wait_d  = 1'b1;
              ready_d = 1'b0;
              state_d = S_RDUMMY;
            end
          end
        end
        S_WDATA: if (sclk_rise) begin
          shift_d = {shift_q[DATA_W-2:0], mosi_s};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == word_last(txn_q)) begin
            cnt_d   = '0;
            wdata_d = shift_d & mask_cur;
            wr_n_d  = txn_q;
`ifdef SPI_REG_BRIDGE_BURST_EN
            inc_d   = 1'b1;
`else
            state_d = S_DONE;
`endif
          end
        end
        S_RDUMMY: begin
          if (sclk_rise) cnt_d = cnt_q + 1'b1;
          if (sclk_fall && cnt_q == CNT_W'(DUMMY_BITS - 1)) miso_d = ready_q;
          if (sclk_fall && cnt_q == CNT_W'(DUMMY_BITS)) begin
            // The first data bit must already be on MISO before the master's next rising edge.
            shift_d = ready_q ? (rcap_q << (DATA_W - (8 << txn_q))) : '0;
            miso_d  = shift_d[DATA_W-1];
            shift_d = shift_d << 1;
            late_d  = ~ready_q;
            wait_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_RDATA;
          end
        end
        S_RDATA: begin
          if (sclk_fall) begin
            miso_d  = shift_q[DATA_W-1];
            shift_d = shift_q << 1;
          end
          if (sclk_rise) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == word_last(txn_q)) begin
              cnt_d  = '0;
              miso_d = 1'b0;
`ifdef SPI_REG_BRIDGE_BURST_EN
              addr_d  = addr_q + ADDR_W'(32'd1 << txn_q);
              rd_n_d  = txn_q;
              wait_d  = 1'b1;
              ready_d = 1'b0;
              state_d = S_RDUMMY;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
        S_DONE:  miso_d = 1'b0;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hdr_q       <= '0;
      txn_q       <= '0;
      addr_q      <= '0;
      shift_q     <= '0;
      wdata_q     <= '0;
      rcap_q      <= '0;
      wait_q      <= 1'b0;
      ready_q     <= 1'b0;
      miso_q      <= 1'b0;
      late_q      <= 1'b0;
      wr_n_q      <= 2'b11;
      rd_n_q      <= 2'b11;
`ifdef SPI_REG_BRIDGE_BURST_EN
      inc_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates so every flop sees the pre-edge value of every other flop.
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      txn_q       <= txn_d;
      addr_q      <= addr_d;
      shift_q     <= shift_d;
      wdata_q     <= wdata_d;
      rcap_q      <= rcap_d;
      wait_q      <= wait_d;
      ready_q     <= ready_d;
      miso_q      <= miso_d;
      late_q      <= late_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
`ifdef SPI_REG_BRIDGE_BURST_EN
      inc_q       <= inc_d;
`endif
    end
  end

  assign spi_miso     = miso_q;
  assign reg_addr     = addr_q;
  assign reg_wdata    = wdata_q;
  assign data_write_n = wr_n_q;
  assign data_read_n  = rd_n_q;
  assign rd_late      = late_q;

endmodule
